// File: rtl/multi_stage_cook_sequencer.sv
// multi_stage_cook_sequencer
// Runs a programmed list of cooking stages, each with its own duration and
// power level. Power is delivered as a per-second heater duty cycle over a
// POWER_MAX-tick window. Handles door interlock, pause/resume and add-time.
//
// Ports:
//   i_clk, i_reset (sync, active-low), i_tick_1hz (1-clk pulse per second)
//   i_cfg_we/i_cfg_idx/i_cfg_time/i_cfg_power : stage programming (IDLE only)
//   i_num_stages : active stage count, sampled at start
//   i_start/i_pause/i_cancel/i_add_time : command pulses; i_door_open : level
//   o_state (0 IDLE,1 RUNNING,2 PAUSED,3 COMPLETE), o_cur_stage, o_remaining_sec
//   o_heater_on, o_motor_enable, o_stage_done, o_cook_done, o_cfg_err
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for start; stage programming accepted
// RUNNING  | counting down current stage, heater duty active, motor on
// PAUSED   | countdown frozen, heater and motor off
// COMPLETE | program finished; alarm countdown then back to IDLE
module multi_stage_cook_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int IDX_W       = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  parameter int TIME_W      = 12,
  parameter int MAX_TIME    = 5999,
  parameter int PWR_W       = 4,
  parameter int POWER_MAX   = 10,
  parameter int ADD_STEP    = 30,
  parameter int ALARM_TICKS = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_tick_1hz,
  input  logic              i_cfg_we,
  input  logic [IDX_W-1:0]  i_cfg_idx,
  input  logic [TIME_W-1:0] i_cfg_time,
  input  logic [PWR_W-1:0]  i_cfg_power,
  input  logic [IDX_W:0]    i_num_stages,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_cancel,
  input  logic              i_add_time,
  input  logic              i_door_open,
  output logic [1:0]        o_state,
  output logic [IDX_W-1:0]  o_cur_stage,
  output logic [TIME_W-1:0] o_remaining_sec,
  output logic              o_heater_on,
  output logic              o_motor_enable,
  output logic              o_stage_done,
  output logic              o_cook_done,
  output logic              o_cfg_err
);

  // The ceiling can never exceed what the seconds counter can hold.
  localparam int TIME_CEIL = (MAX_TIME > (2**TIME_W) - 1) ? (2**TIME_W) - 1 : MAX_TIME;
  localparam int DUTY_LAST_I = POWER_MAX - 1;
  localparam int ALARM_W = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS + 1) : 1;

  localparam logic [TIME_W:0]    CEIL_X    = TIME_CEIL[TIME_W:0];
  localparam logic [TIME_W:0]    ADD_X     = ADD_STEP[TIME_W:0];
  localparam logic [TIME_W-1:0]  T_ONE     = {{(TIME_W-1){1'b0}}, 1'b1};
  localparam logic [PWR_W-1:0]   PMAX      = POWER_MAX[PWR_W-1:0];
  localparam logic [PWR_W-1:0]   DUTY_LAST = DUTY_LAST_I[PWR_W-1:0];
  localparam logic [PWR_W-1:0]   P_ONE     = {{(PWR_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0]     NUM_X     = NUM_STAGES[IDX_W:0];
  localparam logic [IDX_W:0]     I_ONE     = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [ALARM_W-1:0] ALARM_X   = ALARM_TICKS[ALARM_W-1:0];
  localparam logic [ALARM_W-1:0] A_ONE     = {{(ALARM_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_stage;
  logic [TIME_W-1:0]  r_rem;
  logic [PWR_W-1:0]   r_duty;
  logic [IDX_W:0]     r_num;
  logic [ALARM_W-1:0] r_alarm;
  logic               r_heater, r_motor, r_stage_done, r_cook_done, r_cfg_err;
  logic [TIME_W-1:0]  r_time  [NUM_STAGES];
  logic [PWR_W-1:0]   r_power [NUM_STAGES];

  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_stage_nxt;
  logic [TIME_W-1:0]  w_rem_nxt;
  logic [PWR_W-1:0]   w_duty_nxt;
  logic [IDX_W:0]     w_num_nxt;
  logic [ALARM_W-1:0] w_alarm_nxt;
  logic               w_stage_done_nxt, w_cook_done_nxt, w_cfg_err_nxt, w_cfg_wr;

  logic [IDX_W:0]     w_num_clamped;
  logic [IDX_W:0]     w_nxt_idx_x;
  logic [IDX_W-1:0]   w_nxt_idx;
  logic               w_has_next;
  logic               w_add_dec;
  logic [TIME_W:0]    w_add_sum;
  logic [TIME_W-1:0]  w_add_sat;
  logic [PWR_W-1:0]   w_duty_inc;
  logic [TIME_W-1:0]  w_cfg_time_sat;
  logic [PWR_W-1:0]   w_cfg_pwr;

  assign w_num_clamped  = (i_num_stages > NUM_X) ? NUM_X : i_num_stages;
  assign w_nxt_idx_x    = {1'b0, r_stage} + I_ONE;
  assign w_nxt_idx      = w_nxt_idx_x[IDX_W-1:0];
  // Program ends early at the first zero-length stage.
  assign w_has_next     = (w_nxt_idx_x < r_num) && (r_time[w_nxt_idx] != '0);
  // A tick that coincides with add_time is folded into the sum; only RUNNING counts ticks.
  assign w_add_dec      = i_tick_1hz && (r_state == ST_RUN);
  assign w_add_sum      = {1'b0, r_rem} + ADD_X - {{TIME_W{1'b0}}, w_add_dec};
  assign w_add_sat      = (w_add_sum > CEIL_X) ? CEIL_X[TIME_W-1:0] : w_add_sum[TIME_W-1:0];
  assign w_duty_inc     = (r_duty >= DUTY_LAST) ? '0 : r_duty + P_ONE;
  assign w_cfg_time_sat = ({1'b0, i_cfg_time} > CEIL_X) ? CEIL_X[TIME_W-1:0] : i_cfg_time;
  assign w_cfg_pwr      = (i_cfg_power > PMAX) ? PMAX : i_cfg_power;

  always_comb begin
    w_state_nxt      = r_state;
    w_stage_nxt      = r_stage;
    w_rem_nxt        = r_rem;
    w_duty_nxt       = r_duty;
    w_num_nxt        = r_num;
    w_alarm_nxt      = r_alarm;
    w_stage_done_nxt = 1'b0;
    w_cook_done_nxt  = 1'b0;
    w_cfg_wr         = i_cfg_we && (r_state == ST_IDLE);
    w_cfg_err_nxt    = i_cfg_we && (r_state != ST_IDLE);

    if (i_cancel) begin
      w_state_nxt = ST_IDLE;
      w_stage_nxt = '0;
      w_rem_nxt   = '0;
      w_duty_nxt  = '0;
      w_alarm_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if ((w_num_clamped == '0) || (r_time[0] == '0) || i_door_open) begin
              w_cfg_err_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_RUN;
              w_stage_nxt = '0;
              w_rem_nxt   = r_time[0];
              w_duty_nxt  = '0;
              w_num_nxt   = w_num_clamped;
            end
          end
        end
        ST_RUN: begin
          if (i_door_open || i_pause) begin
            w_state_nxt = ST_PAUSE;
          end else if (i_add_time) begin
            w_rem_nxt = w_add_sat;
            if (i_tick_1hz) w_duty_nxt = w_duty_inc;
          end else if (i_tick_1hz) begin
            if (r_rem > T_ONE) begin
              w_rem_nxt  = r_rem - T_ONE;
              w_duty_nxt = w_duty_inc;
            end else begin
              w_stage_done_nxt = 1'b1;
              if (w_has_next) begin
                w_stage_nxt = w_nxt_idx;
                w_rem_nxt   = r_time[w_nxt_idx];
                w_duty_nxt  = '0;
              end else begin
                w_rem_nxt       = '0;
                w_state_nxt     = ST_DONE;
                w_cook_done_nxt = 1'b1;
                w_alarm_nxt     = ALARM_X;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (i_start) begin
            if (i_door_open) w_cfg_err_nxt = 1'b1;
            else             w_state_nxt   = ST_RUN;
          end else if (i_add_time) begin
            w_rem_nxt = w_add_sat;
          end
        end
        ST_DONE: begin
          if (i_tick_1hz) begin
            if (r_alarm <= A_ONE) begin
              w_state_nxt = ST_IDLE;
              w_stage_nxt = '0;
              w_alarm_nxt = '0;
            end else begin
              w_alarm_nxt = r_alarm - A_ONE;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_stage      <= '0;
      r_rem        <= '0;
      r_duty       <= '0;
      r_num        <= '0;
      r_alarm      <= '0;
      r_heater     <= 1'b0;
      r_motor      <= 1'b0;
      r_stage_done <= 1'b0;
      r_cook_done  <= 1'b0;
      r_cfg_err    <= 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_time[k]  <= '0;
        r_power[k] <= '0;
      end
    end else begin
      r_state      <= w_state_nxt;
      r_stage      <= w_stage_nxt;
      r_rem        <= w_rem_nxt;
      r_duty       <= w_duty_nxt;
      r_num        <= w_num_nxt;
      r_alarm      <= w_alarm_nxt;
      r_stage_done <= w_stage_done_nxt;
      r_cook_done  <= w_cook_done_nxt;
      r_cfg_err    <= w_cfg_err_nxt;
      // Heater/motor follow the next state so they line up with the other outputs.
      r_heater     <= (w_state_nxt == ST_RUN) && (w_duty_nxt < r_power[w_stage_nxt]);
      r_motor      <= (w_state_nxt == ST_RUN);
      if (w_cfg_wr && ({1'b0, i_cfg_idx} < NUM_X)) begin
        r_time[i_cfg_idx]  <= w_cfg_time_sat;
        r_power[i_cfg_idx] <= w_cfg_pwr;
      end
    end
  end

  assign o_state         = r_state;
  assign o_cur_stage     = r_stage;
  assign o_remaining_sec = r_rem;
  assign o_heater_on     = r_heater;
  assign o_motor_enable  = r_motor;
  assign o_stage_done    = r_stage_done;
  assign o_cook_done     = r_cook_done;
  assign o_cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_multi_stage_cook_sequencer.sv
// Directed bench for multi_stage_cook_sequencer. Seconds counter is widened
// to 13 bits so the 5999 s ceiling is representable.
module tb_multi_stage_cook_sequencer;

  localparam int IDX_W  = 2;
  localparam int TIME_W = 13;
  localparam int PWR_W  = 4;

  logic              clk = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_tick = 1'b0;
  logic              i_cfg_we = 1'b0;
  logic [IDX_W-1:0]  i_cfg_idx = '0;
  logic [TIME_W-1:0] i_cfg_time = '0;
  logic [PWR_W-1:0]  i_cfg_power = '0;
  logic [IDX_W:0]    i_num = '0;
  logic              i_start = 1'b0;
  logic              i_pause = 1'b0;
  logic              i_cancel = 1'b0;
  logic              i_add = 1'b0;
  logic              i_door = 1'b0;
  logic [1:0]        o_state;
  logic [IDX_W-1:0]  o_stage;
  logic [TIME_W-1:0] o_rem;
  logic              o_heater, o_motor, o_stage_done, o_cook_done, o_cfg_err;

  int n_asserts = 0;
  int n_fail    = 0;

  multi_stage_cook_sequencer #(.TIME_W(TIME_W)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_tick_1hz     (i_tick),
    .i_cfg_we       (i_cfg_we),
    .i_cfg_idx      (i_cfg_idx),
    .i_cfg_time     (i_cfg_time),
    .i_cfg_power    (i_cfg_power),
    .i_num_stages   (i_num),
    .i_start        (i_start),
    .i_pause        (i_pause),
    .i_cancel       (i_cancel),
    .i_add_time     (i_add),
    .i_door_open    (i_door),
    .o_state        (o_state),
    .o_cur_stage    (o_stage),
    .o_remaining_sec(o_rem),
    .o_heater_on    (o_heater),
    .o_motor_enable (o_motor),
    .o_stage_done   (o_stage_done),
    .o_cook_done    (o_cook_done),
    .o_cfg_err      (o_cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    i_tick = 1'b1; cyc(); i_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick1();
  endtask

  task automatic wr(input int idx, input int t, input int p);
    i_cfg_idx = idx[IDX_W-1:0]; i_cfg_time = t[TIME_W-1:0]; i_cfg_power = p[PWR_W-1:0];
    i_cfg_we = 1'b1; cyc(); i_cfg_we = 1'b0;
  endtask

  task automatic do_start();  i_start = 1'b1;  cyc(); i_start = 1'b0;  endtask
  task automatic do_pause();  i_pause = 1'b1;  cyc(); i_pause = 1'b0;  endtask
  task automatic do_cancel(); i_cancel = 1'b1; cyc(); i_cancel = 1'b0; endtask

  initial begin
    // Reset
    cyc(); cyc();
    chk("rst_state", 32'(o_state), 0);
    chk("rst_rem", 32'(o_rem), 0);
    chk("rst_heater", 32'(o_heater), 0);
    chk("rst_motor", 32'(o_motor), 0);
    i_reset = 1'b1;
    cyc();

    // Two-stage program: 5 s @10, 3 s @3
    wr(0, 5, 10);
    chk("cfg_idle_ok", 32'(o_cfg_err), 0);
    wr(1, 3, 3);
    i_num = 3'd2;
    do_start();
    chk("run_state", 32'(o_state), 1);
    chk("run_rem", 32'(o_rem), 5);
    chk("run_heater", 32'(o_heater), 1);
    chk("run_motor", 32'(o_motor), 1);
    ticks(4);
    chk("s0_rem1", 32'(o_rem), 1);
    chk("s0_no_done", 32'(o_stage_done), 0);
    tick1();
    chk("s0_done", 32'(o_stage_done), 1);
    chk("s1_stage", 32'(o_stage), 1);
    chk("s1_rem", 32'(o_rem), 3);
    chk("s1_heater0", 32'(o_heater), 1);
    cyc();
    chk("done_pulse_clr", 32'(o_stage_done), 0);
    ticks(2);
    chk("s1_rem1", 32'(o_rem), 1);
    chk("s1_heater2", 32'(o_heater), 1);
    tick1();
    chk("cook_done", 32'(o_cook_done), 1);
    chk("s1_done", 32'(o_stage_done), 1);
    chk("cmp_state", 32'(o_state), 3);
    chk("cmp_rem", 32'(o_rem), 0);
    chk("cmp_stage", 32'(o_stage), 1);
    chk("cmp_heater", 32'(o_heater), 0);
    chk("cmp_motor", 32'(o_motor), 0);
    cyc();
    chk("cook_done_clr", 32'(o_cook_done), 0);
    ticks(2);
    chk("alarm_hold", 32'(o_state), 3);
    tick1();
    chk("alarm_idle", 32'(o_state), 0);
    chk("alarm_stage0", 32'(o_stage), 0);

    // Start rejections and config while running
    wr(0, 0, 5);
    do_start();
    chk("rej_t0_err", 32'(o_cfg_err), 1);
    chk("rej_t0_state", 32'(o_state), 0);
    cyc();
    chk("rej_err_clr", 32'(o_cfg_err), 0);
    wr(0, 5, 10);
    i_door = 1'b1;
    do_start();
    chk("rej_door_err", 32'(o_cfg_err), 1);
    chk("rej_door_state", 32'(o_state), 0);
    i_door = 1'b0;
    i_num = 3'd0;
    do_start();
    chk("rej_num0_err", 32'(o_cfg_err), 1);
    i_num = 3'd2;
    do_start();
    chk("restart_state", 32'(o_state), 1);
    wr(1, 9, 9);
    chk("cfg_run_err", 32'(o_cfg_err), 1);
    chk("cfg_run_state", 32'(o_state), 1);
    ticks(5);
    chk("cfg_kept_stage", 32'(o_stage), 1);
    chk("cfg_kept_rem", 32'(o_rem), 3);
    do_cancel();
    chk("cancel_state", 32'(o_state), 0);
    chk("cancel_rem", 32'(o_rem), 0);
    chk("cancel_stage", 32'(o_stage), 0);

    // Door interlock with a partial duty cycle (power 4)
    wr(0, 10, 4);
    i_num = 3'd1;
    do_start();
    ticks(3);
    chk("duty3_on", 32'(o_heater), 1);
    tick1();
    chk("door_rem6", 32'(o_rem), 6);
    chk("duty4_off", 32'(o_heater), 0);
    i_door = 1'b1;
    cyc();
    chk("door_paused", 32'(o_state), 2);
    chk("door_motor", 32'(o_motor), 0);
    chk("door_heater", 32'(o_heater), 0);
    ticks(5);
    chk("door_hold_rem", 32'(o_rem), 6);
    chk("door_hold_state", 32'(o_state), 2);
    i_door = 1'b0;
    do_start();
    chk("resume_state", 32'(o_state), 1);
    chk("resume_motor", 32'(o_motor), 1);
    chk("resume_rem", 32'(o_rem), 6);
    do_pause();
    chk("pause_state", 32'(o_state), 2);
    tick1();
    chk("pause_tick_ign", 32'(o_rem), 6);
    do_start();
    chk("resume2_state", 32'(o_state), 1);
    ticks(5);
    chk("door_rem1", 32'(o_rem), 1);
    tick1();
    chk("door_cook_done", 32'(o_cook_done), 1);
    chk("door_complete", 32'(o_state), 3);
    do_cancel();

    // Add-time saturation and stacking
    wr(0, 5980, 10);
    do_start();
    chk("add_start_rem", 32'(o_rem), 5980);
    i_add = 1'b1; i_tick = 1'b1; cyc(); i_add = 1'b0; i_tick = 1'b0;
    chk("add_tick_sat", 32'(o_rem), 5999);
    i_add = 1'b1; cyc(); i_add = 1'b0;
    chk("add_sat_hold", 32'(o_rem), 5999);
    do_cancel();
    wr(0, 8000, 10);
    do_start();
    chk("cfg_time_sat", 32'(o_rem), 5999);
    do_cancel();
    wr(0, 17, 1);
    do_start();
    ticks(9);
    chk("wrap_rem8", 32'(o_rem), 8);
    chk("duty9_off", 32'(o_heater), 0);
    tick1();
    chk("wrap_rem7", 32'(o_rem), 7);
    chk("duty_wrap_on", 32'(o_heater), 1);
    i_add = 1'b1; i_tick = 1'b1; cyc(); i_add = 1'b0; i_tick = 1'b0;
    chk("add_tick_36", 32'(o_rem), 36);
    do_pause();
    i_add = 1'b1; cyc(); i_add = 1'b0;
    chk("add_paused_66", 32'(o_rem), 66);
    do_cancel();

    // Cancel + pause + final tick together: no done pulses
    wr(0, 2, 10);
    do_start();
    tick1();
    chk("cp_rem1", 32'(o_rem), 1);
    i_cancel = 1'b1; i_pause = 1'b1; i_tick = 1'b1; cyc();
    i_cancel = 1'b0; i_pause = 1'b0; i_tick = 1'b0;
    chk("cp_state", 32'(o_state), 0);
    chk("cp_rem", 32'(o_rem), 0);
    chk("cp_stage_done", 32'(o_stage_done), 0);
    chk("cp_cook_done", 32'(o_cook_done), 0);
    chk("cp_motor", 32'(o_motor), 0);

    // Reset mid-stage wipes program
    wr(0, 2, 10);
    wr(1, 5, 5);
    i_num = 3'd2;
    do_start();
    ticks(2);
    chk("mid_stage1", 32'(o_stage), 1);
    chk("mid_rem5", 32'(o_rem), 5);
    i_reset = 1'b0;
    cyc();
    chk("mrst_state", 32'(o_state), 0);
    chk("mrst_stage", 32'(o_stage), 0);
    chk("mrst_rem", 32'(o_rem), 0);
    chk("mrst_heater", 32'(o_heater), 0);
    chk("mrst_motor", 32'(o_motor), 0);
    i_reset = 1'b1;
    cyc();
    do_start();
    chk("mrst_cleared_err", 32'(o_cfg_err), 1);
    chk("mrst_cleared_state", 32'(o_state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
